// File: rtl/game_pkg.sv
// Shared minesweeper types: coordinates, board map, placer states and cell helpers.
package game_pkg;

  localparam int unsigned GRID_DIM = 8;
  localparam int unsigned COORD_W  = 3;
  localparam int unsigned CELL_W   = 6;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [63:0]        board_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } placer_state_t;

  // Flat board index of a cell: row*8 + col.
  function automatic logic [CELL_W-1:0] cell_idx(input coord_t row, input coord_t col);
    return {row, col};
  endfunction

  function automatic logic in_grid(input int v);
    return (v >= 0) && (v < int'(GRID_DIM));
  endfunction

endpackage

// File: rtl/neighbor_counter.sv
// Combinational count of bombs in the in-grid 8-neighbourhood of one cell.
module neighbor_counter
  import game_pkg::*;
(
  input  board_t      board,
  input  coord_t      row,
  input  coord_t      col,
  output logic [3:0]  count
);

  always_comb begin
    count = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((dr != 0 || dc != 0) && in_grid(int'(row) + dr) && in_grid(int'(col) + dc))
          count = count + 4'(board[cell_idx(COORD_W'(int'(row) + dr), COORD_W'(int'(col) + dc))]);
      end
    end
  end

endmodule

// File: rtl/bomb_placer.sv
// Places N_BOMBS distinct bombs from a coordinate stream, skipping duplicates and the safe cell.
module bomb_placer
  import game_pkg::*;
#(
  parameter int unsigned N_BOMBS = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  coord_t            safe_row,
  input  coord_t            safe_col,
  input  logic              coord_valid,
  input  coord_t            coord_row,
  input  coord_t            coord_col,
  output logic              coord_ready,
  output board_t            board,
  output logic [CELL_W-1:0] bomb_count,
  output logic [7:0]        reject_count,
  output logic              busy,
  output logic              done,
  input  coord_t            query_row,
  input  coord_t            query_col,
  output logic              query_bomb,
  output logic [3:0]        query_adj
);

  localparam logic [CELL_W-1:0] LAST_COUNT = CELL_W'(N_BOMBS);

  placer_state_t     state;
  logic [CELL_W-1:0] safe_idx;
  logic [CELL_W-1:0] idx;
  logic [CELL_W-1:0] next_count;

  assign idx        = cell_idx(coord_row, coord_col);
  assign next_count = bomb_count + CELL_W'(1);

  // Fill FSM; coord_ready/busy/done are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      safe_idx     <= '0;
      board        <= '0;
      bomb_count   <= '0;
      reject_count <= '0;
      coord_ready  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= FILL;
            safe_idx     <= cell_idx(safe_row, safe_col);
            board        <= '0;
            bomb_count   <= '0;
            reject_count <= '0;
            coord_ready  <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end
        FILL: begin
          if (coord_valid) begin
            if (board[idx] || (idx == safe_idx)) begin
              if (reject_count != 8'hFF) reject_count <= reject_count + 8'd1;
            end else begin
              board[idx] <= 1'b1;
              bomb_count <= next_count;
              if (next_count == LAST_COUNT) begin
                state       <= DONE;
                coord_ready <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b1;
              end
            end
          end
        end
        default: begin
          state       <= IDLE;
          coord_ready <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

  assign query_bomb = board[cell_idx(query_row, query_col)];

  neighbor_counter u_adj (
    .board (board),
    .row   (query_row),
    .col   (query_col),
    .count (query_adj)
  );

endmodule

// File: tb/tb_bomb_placer.sv
// Self-checking bench for bomb_placer with N_BOMBS = 3: scoreboarded fill cycles plus a query table.
module tb_bomb_placer;
  import game_pkg::*;

  localparam int unsigned NB = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  coord_t      safe_row, safe_col;
  logic        coord_valid;
  coord_t      coord_row, coord_col;
  logic        coord_ready;
  board_t      board;
  logic [5:0]  bomb_count;
  logic [7:0]  reject_count;
  logic        busy, done;
  coord_t      query_row, query_col;
  logic        query_bomb;
  logic [3:0]  query_adj;

  bomb_placer #(.N_BOMBS(NB)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .safe_row     (safe_row),
    .safe_col     (safe_col),
    .coord_valid  (coord_valid),
    .coord_row    (coord_row),
    .coord_col    (coord_col),
    .coord_ready  (coord_ready),
    .board        (board),
    .bomb_count   (bomb_count),
    .reject_count (reject_count),
    .busy         (busy),
    .done         (done),
    .query_row    (query_row),
    .query_col    (query_col),
    .query_bomb   (query_bomb),
    .query_adj    (query_adj)
  );

  always #5 clk = ~clk;

  typedef struct {
    board_t     board;
    logic [5:0] cnt;
    logic [7:0] rej;
    logic       ready;
    logic       done;
  } exp_t;

  typedef struct {
    coord_t     row;
    coord_t     col;
    logic       bomb;
    logic [3:0] adj;
  } qvec_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  board_t     m_board;
  logic [5:0] m_cnt;
  logic [7:0] m_rej;
  logic       m_fill;
  logic       m_done;
  int         m_safe;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_board = '0; m_cnt = '0; m_rej = '0; m_fill = 1'b0; m_done = 1'b0; m_safe = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " board"},  board, 64'h0);
    chk({tag, " count"},  64'(bomb_count), 64'h0);
    chk({tag, " reject"}, 64'(reject_count), 64'h0);
    chk({tag, " ready"},  64'(coord_ready), 64'h0);
    chk({tag, " busy"},   64'(busy), 64'h0);
    chk({tag, " done"},   64'(done), 64'h0);
  endtask

  // One clock cycle: drive, predict, push expectation, pop and compare after the edge.
  task automatic cycle(input logic st, input int srow, input int scol,
                       input logic v, input int row, input int col);
    exp_t e, got;
    int   idx;
    start = st; safe_row = 3'(srow); safe_col = 3'(scol);
    coord_valid = v; coord_row = 3'(row); coord_col = 3'(col);
    if (!m_fill) begin
      if (st) begin
        m_board = '0; m_cnt = '0; m_rej = '0;
        m_safe = srow * 8 + scol; m_fill = 1'b1; m_done = 1'b0;
      end
    end else if (v) begin
      idx = row * 8 + col;
      if (m_board[idx] || idx == m_safe) begin
        if (m_rej != 8'd255) m_rej = m_rej + 8'd1;
      end else begin
        m_board[idx] = 1'b1;
        m_cnt = m_cnt + 6'd1;
        if (int'(m_cnt) == int'(NB)) begin m_fill = 1'b0; m_done = 1'b1; end
      end
    end
    e.board = m_board; e.cnt = m_cnt; e.rej = m_rej; e.ready = m_fill; e.done = m_done;
    sbq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; coord_valid = 1'b0;
    got = sbq.pop_front();
    chk("sb board",  board, got.board);
    chk("sb count",  64'(bomb_count), 64'(got.cnt));
    chk("sb reject", 64'(reject_count), 64'(got.rej));
    chk("sb ready",  64'(coord_ready), 64'(got.ready));
    chk("sb busy",   64'(busy), 64'(got.ready));
    chk("sb done",   64'(done), 64'(got.done));
  endtask

  task automatic send(input int row, input int col);
    cycle(1'b0, 0, 0, 1'b1, row, col);
  endtask

  task automatic do_start(input int srow, input int scol);
    cycle(1'b1, srow, scol, 1'b0, 0, 0);
  endtask

  // Independent neighbour model: scan every cell for Chebyshev distance 1.
  function automatic int ref_adj(input board_t b, input int qr, input int qc);
    int n = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int ar = (r > qr) ? r - qr : qr - r;
        int ac = (c > qc) ? c - qc : qc - c;
        if (ar <= 1 && ac <= 1 && !(ar == 0 && ac == 0) && b[r*8+c]) n++;
      end
    return n;
  endfunction

  task automatic sweep_queries(input string tag);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        query_row = 3'(r); query_col = 3'(c); #1;
        chk({tag, " qbomb"}, 64'(query_bomb), 64'(m_board[r*8+c]));
        chk({tag, " qadj"},  64'(query_adj), 64'(ref_adj(m_board, r, c)));
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    qvec_t qtab[9];
    qtab[0] = '{3'd0, 3'd0, 1'b0, 4'd3};
    qtab[1] = '{3'd7, 3'd7, 1'b0, 4'd0};
    qtab[2] = '{3'd1, 3'd1, 1'b1, 4'd2};
    qtab[3] = '{3'd0, 3'd1, 1'b1, 4'd2};
    qtab[4] = '{3'd1, 3'd0, 1'b1, 4'd2};
    qtab[5] = '{3'd2, 3'd2, 1'b0, 4'd1};
    qtab[6] = '{3'd0, 3'd2, 1'b0, 4'd2};
    qtab[7] = '{3'd2, 3'd0, 1'b0, 4'd2};
    qtab[8] = '{3'd1, 3'd2, 1'b0, 4'd2};

    reset = 1'b0; start = 1'b0; safe_row = '0; safe_col = '0;
    coord_valid = 1'b0; coord_row = '0; coord_col = '0;
    query_row = '0; query_col = '0;
    model_reset();

    // Reset state; coordinates offered in IDLE are not consumed
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1 check_all_zero("reset");
    send(3, 3);
    send(3, 3);

    // Three distinct bombs back-to-back, safe (0,0)
    do_start(0, 0);
    send(1, 1); send(2, 2); send(3, 3);
    chk("fill3 board const", board, 64'h0000_0000_0804_0200);
    chk("fill3 done", 64'(done), 64'h1);
    send(4, 4);
    sweep_queries("fill3");

    // Duplicates, safe cell, ignored start in FILL, and reject saturation
    do_start(0, 0);
    send(1, 1); send(1, 1); send(0, 0);
    cycle(1'b1, 5, 5, 1'b1, 1, 1);
    chk("dup reject 3", 64'(reject_count), 64'd3);
    send(4, 5);
    for (int i = 0; i < 254; i++) send(0, 0);
    chk("reject saturated", 64'(reject_count), 64'd255);
    send(6, 6);
    chk("dup board const", board, 64'h0040_0020_0000_0200);
    chk("dup done", 64'(done), 64'h1);

    // Start in DONE with a coordinate in the same cycle: start wins, coordinate dropped
    cycle(1'b1, 7, 7, 1'b1, 3, 3);
    chk("restart clears reject", 64'(reject_count), 64'd0);
    send(0, 1); send(7, 7); send(1, 0); send(1, 1);
    chk("safe77 reject", 64'(reject_count), 64'd1);
    for (int i = 0; i < 9; i++) begin
      query_row = qtab[i].row; query_col = qtab[i].col; #1;
      chk($sformatf("qtab%0d bomb", i), 64'(query_bomb), 64'(qtab[i].bomb));
      chk($sformatf("qtab%0d adj", i),  64'(query_adj),  64'(qtab[i].adj));
    end
    sweep_queries("corner");

    // Reset dropped mid-FILL clears everything asynchronously
    do_start(3, 3);
    send(2, 5); send(6, 1);
    reset = 1'b0;
    #1 check_all_zero("async reset");
    sbq.delete();
    model_reset();
    @(posedge clk); #1 reset = 1'b1;
    send(5, 5);
    do_start(3, 3);
    send(5, 5);
    chk("refill board const", board, 64'h0000_2000_0000_0000);
    chk("refill count", 64'(bomb_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
